wb_arbiter: RTL and testbench
=============================

# wb_arbiter

- Sits in front of the register file's single write port.
- Merges two result sources onto that port:
  - the in-order pipeline WB stage, which is never stalled and always has priority;
  - a late-result source, such as the multi-cycle mul/div unit, using a valid/ready handshake.
- Late results wait in a small FIFO and drain into cycles where the pipeline does not write.
- Provides kill-on-overwrite ordering and read-hazard flags for the decode stage.

## Interface
- DEPTH, 2, late-result FIFO entries (power of two, ≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- pipe_we  in  1  WB-stage write request; always accepted.
- pipe_addr  in  5  WB-stage destination register.
- pipe_data  in  32  WB-stage result.
- late_valid  in  1  late result offered.
- late_ready  out  1  late result accepted this cycle when high with late_valid. Equal to !full && !rst.
- late_addr  in  5  late destination register.
- late_data  in  32  late result.
- write_en  out  1  registered write enable to register file.
- data_addr  out  5  registered write address.
- data_in  out  32  registered write data.
- rd_addr1, rd_addr2  in  5 each  decode-stage read addresses.
- hazard1, hazard2  out  1 each  read address has a pending late write (combinational).
- drain_req  out  1  FIFO full; decode should insert a bubble so the FIFO can drain.

## Operation
- **FIFO.** DEPTH entries {valid, addr, data} with rd/wr pointers and a count.
  - full = (count == DEPTH).
  - Pointers wrap modulo DEPTH.
- **Enqueue.** Happens when late_valid && late_ready.
  - If late_addr == 0, the handshake completes but nothing is stored.
- **Output select, per cycle:**
  - Pipe write: if pipe_we && pipe_addr != 0, register {1, pipe_addr, pipe_data}.
  - Drain: otherwise, if the FIFO head is a valid entry, register {1, head.addr, head.data} and pop.
  - Discard: if the head entry is killed, pop it without writing and register write_en=0. At most one pop per cycle.
  - Idle: otherwise write_en=0, and data_addr/data_in hold their previous values.
- **Kill rule (WAW ordering).** A late result is always older than a concurrent or later pipe write to the same register.
  - When pipe_we && pipe_addr != 0, every FIFO entry with addr == pipe_addr has its valid bit cleared.
  - An entry being enqueued in the same cycle with late_addr == pipe_addr is stored with valid=0.
- **Hazard flags.** hazardN = (rd_addrN != 0) && (either of the following):
  - any valid FIFO entry has addr == rd_addrN;
  - write_en && data_addr == rd_addrN, where the output register currently holds a late-sourced write. Track this with an internal late_src flag.
- **Simultaneous enqueue and pop.** Count is unchanged. A full FIFO popping this cycle still reports late_ready=0; there is no bypass.
- **Drain request.** drain_req = full. The bubble it causes gives a drain slot on the next cycle.

## Timing
- Latency: input cycle N produces write_en/data_addr/data_in valid in cycle N+1. The register file captures the write on the falling edge within cycle N+1.
- Late path minimum latency: enqueue in cycle N, head at N+1, drain at N+1 if no pipe write, output at N+2.
- Reset: applies on any rising edge with rst=1, including mid-drain.
  - write_en=0, data_addr=0, data_in=0, late_src=0.
  - FIFO emptied: count=0, pointers=0, all valid=0.
  - late_ready=0 while rst=1; hazard1/2=0 and drain_req=0 from the cycle after reset.
  - Pending late results are lost; the owner of the late source must also be reset.
- Outputs write_en, data_addr and data_in are registered. late_ready, hazardN and drain_req are combinational from state and inputs.

## Test plan
- Pipe only: pipe_we=1, addr=5, data=0x1234 at cycle N -> write_en=1, data_addr=5, data_in=0x1234 at N+1. Pipe addr 0 -> write_en=0.
- Late drain: late_valid, addr=7, data=0xCAFE accepted at N with pipe idle.
  - Output 7/0xCAFE at N+2.
  - hazard1=1 for rd_addr1=7 from N+1 through N+2.
  - hazard1=0 at N+3.
- Priority/fill:
  - Continuous pipe writes with three late results offered -> two accepted, late_ready=0 and drain_req=1 when full.
  - One pipe bubble -> one late write comes out, late_ready returns to 1.
  - FIFO order is preserved.
- Kill: late addr=9 queued, then pipe write addr=9 data=0x1 -> final output writes 0x1 only. The killed entry is popped with write_en=0 and hazard for 9 drops. Same-cycle enqueue plus pipe write to 9 behaves the same.
- Reset mid-operation: FIFO holding 2 entries, rst=1 for one cycle -> write_en=0, hazards 0, late_ready=1 afterwards, no stale write ever appears.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: WB-stage write, late-result handshake,
// register-file write port and decode-stage hazard lookups.
interface wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        late_valid;
    logic        late_ready;
    logic [4:0]  late_addr;
    logic [31:0] late_data;
    logic        write_en;
    logic [4:0]  data_addr;
    logic [31:0] data_in;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        drain_req;

    modport master (
        output pipe_we, pipe_addr, pipe_data, late_valid, late_addr, late_data,
        output rd_addr1, rd_addr2,
        input  late_ready, write_en, data_addr, data_in, hazard1, hazard2, drain_req
    );

    modport slave (
        input  pipe_we, pipe_addr, pipe_data, late_valid, late_addr, late_data,
        input  rd_addr1, rd_addr2,
        output late_ready, write_en, data_addr, data_in, hazard1, hazard2, drain_req
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, late results queue
// in a small FIFO and drain into idle cycles, with WAW kill and hazard flags.
module wb_arbiter #(
    parameter int unsigned DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             late_src_q, late_src_d;

    logic full, enq, store, pipe_wr, pop, head_vld;

    always_comb begin
        full     = (count_q == CntW'(DEPTH));
        pipe_wr  = bus.pipe_we && (bus.pipe_addr != 5'd0);
        enq      = bus.late_valid && !full && !rst;
        // Address-0 results complete the handshake but are dropped.
        store    = enq && (bus.late_addr != 5'd0);
        pop      = !pipe_wr && (count_q != '0);
        head_vld = vld_q[rd_ptr_q];

        for (int unsigned i = 0; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i] && !(pipe_wr && (addr_q[i] == bus.pipe_addr));
        end
        if (pop) vld_d[rd_ptr_q] = 1'b0;
        if (store) vld_d[wr_ptr_q] = !(pipe_wr && (bus.late_addr == bus.pipe_addr));

        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = store ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CntW'(store) - CntW'(pop);

        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        late_src_d = 1'b0;
        if (pipe_wr) begin
            we_d    = 1'b1;
            waddr_d = bus.pipe_addr;
            wdata_d = bus.pipe_data;
        end else if (pop && head_vld) begin
            we_d       = 1'b1;
            waddr_d    = addr_q[rd_ptr_q];
            wdata_d    = data_q[rd_ptr_q];
            late_src_d = 1'b1;
        end
    end

    always_comb begin
        bus.late_ready = !full && !rst;
        bus.drain_req  = full;
        bus.write_en   = we_q;
        bus.data_addr  = waddr_q;
        bus.data_in    = wdata_q;
        bus.hazard1    = we_q && late_src_q && (waddr_q == bus.rd_addr1);
        bus.hazard2    = we_q && late_src_q && (waddr_q == bus.rd_addr2);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == bus.rd_addr1)) bus.hazard1 = 1'b1;
            if (vld_q[i] && (addr_q[i] == bus.rd_addr2)) bus.hazard2 = 1'b1;
        end
        if (bus.rd_addr1 == 5'd0) bus.hazard1 = 1'b0;
        if (bus.rd_addr2 == 5'd0) bus.hazard2 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            late_src_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            late_src_q <= late_src_d;
            if (store) begin
                addr_q[wr_ptr_q] <= bus.late_addr;
                data_q[wr_ptr_q] <= bus.late_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned DEPTH = 2;

    logic clk;
    logic rst;
    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic        m_late;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_tests;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_haz(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i].v && q[i].a == ra) return 1'b1;
        return m_we && m_late && (m_addr == ra);
    endfunction

    task automatic step(input logic r, input logic pwe, input logic [4:0] pa,
                        input logic [31:0] pd, input logic lv, input logic [4:0] la,
                        input logic [31:0] ld, input logic [4:0] r1, input logic [4:0] r2);
        logic exp_ready;
        logic pw;
        ent_t e;
        rst = r;
        bus.pipe_we = pwe;   bus.pipe_addr = pa;  bus.pipe_data = pd;
        bus.late_valid = lv; bus.late_addr = la;  bus.late_data = ld;
        bus.rd_addr1 = r1;   bus.rd_addr2 = r2;
        #2;
        exp_ready = (q.size() < DEPTH) && !r;
        chk("late_ready", 32'(bus.late_ready), 32'(exp_ready));
        chk("drain_req", 32'(bus.drain_req), 32'(q.size() == DEPTH));
        chk("hazard1", 32'(bus.hazard1), 32'(m_haz(r1)));
        chk("hazard2", 32'(bus.hazard2), 32'(m_haz(r2)));
        if (r) begin
            q.delete();
            m_we = 1'b0; m_late = 1'b0; m_addr = '0; m_data = '0;
        end else begin
            pw = pwe && (pa != 5'd0);
            if (pw) begin
                foreach (q[i]) if (q[i].a == pa) q[i].v = 1'b0;
                m_we = 1'b1; m_late = 1'b0; m_addr = pa; m_data = pd;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = e.v; m_late = e.v;
                if (e.v) begin m_addr = e.a; m_data = e.d; end
            end else begin
                m_we = 1'b0; m_late = 1'b0;
            end
            if (lv && exp_ready && la != 5'd0) begin
                e.v = !(pw && la == pa); e.a = la; e.d = ld;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("write_en", 32'(bus.write_en), 32'(m_we));
        chk("data_addr", 32'(bus.data_addr), 32'(m_addr));
        chk("data_in", bus.data_in, m_data);
    endtask

    task automatic idle(input logic [4:0] r1);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, 5'd0);
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        q.delete();
        m_we = 1'b0; m_late = 1'b0; m_addr = '0; m_data = '0;
        rst = 1'b1;
        bus.pipe_we = 1'b0;   bus.pipe_addr = '0; bus.pipe_data = '0;
        bus.late_valid = 1'b0; bus.late_addr = '0; bus.late_data = '0;
        bus.rd_addr1 = '0;    bus.rd_addr2 = '0;
        @(posedge clk);
        #1;
        chk("rst_write_en", 32'(bus.write_en), 32'd0);
        chk("rst_data_addr", 32'(bus.data_addr), 32'd0);
        chk("rst_data_in", bus.data_in, 32'd0);

        // Pipe only, then pipe to r0.
        step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        chk("pipe_we_out", 32'(bus.write_en), 32'd1);
        chk("pipe_data_out", bus.data_in, 32'h1234);
        step(1'b0, 1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("pipe_r0_we", 32'(bus.write_en), 32'd0);

        // Late drain with hazard window.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hcafe, 5'd7, 5'd0);
        idle(5'd7);
        chk("late_out_data", bus.data_in, 32'hcafe);
        idle(5'd7);
        idle(5'd7);

        // Fill under continuous pipe writes, then one bubble.
        step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'ha0, 5'd10, 5'd11);
        step(1'b0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd11, 32'ha1, 5'd10, 5'd11);
        step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'ha2, 5'd12, 5'd11);
        step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'ha2, 5'd12, 5'd10);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'ha2, 5'd12, 5'd10);
        chk("fill_first_out", bus.data_in, 32'ha0);
        step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'ha2, 5'd12, 5'd11);
        idle(5'd11);
        idle(5'd12);
        idle(5'd12);

        // Kill after queueing, then same-cycle kill.
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
        step(1'b0, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        idle(5'd9);
        idle(5'd9);
        step(1'b0, 1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 32'h3, 5'd9, 5'd9);
        idle(5'd9);
        idle(5'd9);

        // Reset with a full FIFO.
        step(1'b0, 1'b1, 5'd1, 32'h5, 1'b1, 5'd13, 32'hb0, 5'd13, 5'd14);
        step(1'b0, 1'b1, 5'd2, 32'h6, 1'b1, 5'd14, 32'hb1, 5'd13, 5'd14);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hb2, 5'd13, 5'd14);
        idle(5'd13);
        idle(5'd14);
        idle(5'd13);

        // Random traffic with small address range to force collisions.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 7)), $urandom(),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
